// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse access controller.
//   efuse_state_t : sequencer states
//   efuse_pins_t  : bundle of the pins driven into the eFuse macro
//   PINS_IDLE     : pin values whenever no access is in progress
//   mode_pins()   : pin values for a program or read access (STROBE low)
package efuse_pkg;

    typedef enum logic [2:0] {
        BOOT_REQ = 3'd0,
        IDLE     = 3'd1,
        SETUP    = 3'd2,
        PULSE    = 3'd3,
        HOLD     = 3'd4,
        DONE     = 3'd5
    } efuse_state_t;

    typedef struct packed {
        logic       csb;
        logic       strobe;
        logic       load;
        logic       pgenb;
        logic       vddq;
        logic [9:0] a;
    } efuse_pins_t;

    localparam efuse_pins_t PINS_IDLE = '{
        csb:    1'b1,
        strobe: 1'b0,
        load:   1'b0,
        pgenb:  1'b1,
        vddq:   1'b0,
        a:      10'd0
    };

    // Reads leave the bit field of A at zero; only programs select a bit.
    function automatic efuse_pins_t mode_pins(input logic       wr,
                                              input logic [2:0] bit_sel,
                                              input logic [6:0] addr);
        efuse_pins_t p;
        p.csb    = 1'b0;
        p.strobe = 1'b0;
        p.load   = ~wr;
        p.pgenb  = ~wr;
        p.vddq   = wr;
        p.a      = wr ? {bit_sel, addr} : {3'b000, addr};
        return p;
    endfunction

endpackage

// File: rtl/efuse_timer.sv
// Shared down-counter timing the SETUP, PULSE and HOLD phases.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (N-1 for an N-cycle phase)
//   load_val  : value to load
//   value     : current count
//   zero      : count has reached zero (phase ends this cycle)
module efuse_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 8'd0;
        end else if (load) begin
            value <= load_val;
        end else if (value != 8'd0) begin
            value <= value - 8'd1;
        end
    end

    assign zero = (value == 8'd0);

endmodule

// File: rtl/efuse_access_ctrl.sv
// eFuse access sequencer: boot-time shadow read of the first BOOT_WORDS
// words, then single read/program requests driven onto the macro pins.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only while IDLE)
//   req_wr/addr/bit       : 1=program bit req_bit of word req_addr, 0=read
//   rsp_valid/rsp_data    : one-cycle response; read data or 0 for program
//   boot_done/boot_data   : shadow copy of words 0..BOOT_WORDS-1
//   CSB..PGENB, A, Q      : eFuse macro interface
//
// state    | meaning
// BOOT_REQ | launch read of boot word boot_idx
// IDLE     | waiting for a request
// SETUP    | mode pins valid, STROBE low for T_SETUP cycles
// PULSE    | STROBE high for T_PGM or T_RD cycles
// HOLD     | STROBE low, mode pins held T_HOLD cycles; Q captured first cycle
// DONE     | pins idle, respond (or store boot word), then IDLE/BOOT_REQ
module efuse_access_ctrl
    import efuse_pkg::*;
#(
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_PGM      = 20,
    parameter int unsigned T_RD       = 4,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned BOOT_WORDS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [6:0]              req_addr,
    input  logic [2:0]              req_bit,
    output logic                    rsp_valid,
    output logic [7:0]              rsp_data,
    output logic                    boot_done,
    output logic [8*BOOT_WORDS-1:0] boot_data,
    output logic                    CSB,
    output logic                    STROBE,
    output logic                    LOAD,
    output logic                    VDDQ,
    output logic                    PGENB,
    output logic [9:0]              A,
    input  logic [7:0]              Q
);

    localparam logic [7:0] LD_SETUP  = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_PGM    = 8'(T_PGM - 1);
    localparam logic [7:0] LD_RD     = 8'(T_RD - 1);
    localparam logic [7:0] LD_HOLD   = 8'(T_HOLD - 1);
    localparam logic [6:0] LAST_WORD = 7'(BOOT_WORDS - 1);

    efuse_state_t            state, state_nxt;
    logic                    op_wr;
    logic [6:0]              op_addr;
    logic [2:0]              op_bit;
    logic [7:0]              cap_q;
    logic [6:0]              boot_idx;
    logic                    boot_done_r;
    logic [8*BOOT_WORDS-1:0] boot_data_r;
    logic                    accept;
    logic                    capture;
    logic                    tmr_load;
    logic [7:0]              tmr_val;
    logic [7:0]              tmr_value;
    logic                    tmr_zero;
    efuse_pins_t             pins;

    efuse_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = LD_SETUP;
        pins      = PINS_IDLE;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        boot_done = boot_done_r;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            BOOT_REQ: begin
                tmr_load  = 1'b1;
                state_nxt = SETUP;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                pins = mode_pins(op_wr, op_bit, op_addr);
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_val   = op_wr ? LD_PGM : LD_RD;
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                pins        = mode_pins(op_wr, op_bit, op_addr);
                pins.strobe = 1'b1;
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_val   = LD_HOLD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                pins = mode_pins(op_wr, op_bit, op_addr);
                // Counter still holds its load value only on the first HOLD cycle.
                capture = (tmr_value == LD_HOLD);
                if (tmr_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!boot_done_r) begin
                    if (boot_idx == LAST_WORD) begin
                        boot_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BOOT_REQ;
                    end
                end else begin
                    rsp_valid = 1'b1;
                    rsp_data  = op_wr ? 8'h00 : cap_q;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = BOOT_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT_REQ;
            op_wr       <= 1'b0;
            op_addr     <= 7'd0;
            op_bit      <= 3'd0;
            cap_q       <= 8'h00;
            boot_idx    <= 7'd0;
            boot_done_r <= 1'b0;
            boot_data_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_wr   <= req_wr;
                op_addr <= req_addr;
                op_bit  <= req_bit;
            end else if (state == BOOT_REQ) begin
                op_wr   <= 1'b0;
                op_addr <= boot_idx;
                op_bit  <= 3'd0;
            end
            if (capture && !op_wr) begin
                cap_q <= Q;
                // Shadow words are written only during boot, never afterwards.
                if (!boot_done_r) begin
                    for (int n = 0; n < int'(BOOT_WORDS); n++) begin
                        if (boot_idx == 7'(n)) begin
                            boot_data_r[8*n +: 8] <= Q;
                        end
                    end
                end
            end
            if (state == DONE && !boot_done_r) begin
                if (boot_idx == LAST_WORD) begin
                    boot_done_r <= 1'b1;
                end else begin
                    boot_idx <= boot_idx + 7'd1;
                end
            end
        end
    end

    assign boot_data = boot_data_r;
    assign CSB       = pins.csb;
    assign STROBE    = pins.strobe;
    assign LOAD      = pins.load;
    assign VDDQ      = pins.vddq;
    assign PGENB     = pins.pgenb;
    assign A         = pins.a;

endmodule

// File: tb/tb_efuse_access_ctrl.sv
// Bench for efuse_access_ctrl: eFuse macro model, transaction-timeline
// reference model checked every cycle, directed scenarios, random requests.
module tb_efuse_access_ctrl;

    localparam int T_SETUP = 2;
    localparam int T_PGM   = 20;
    localparam int T_RD    = 4;
    localparam int T_HOLD  = 2;
    localparam int BW      = 10;
    localparam logic [79:0] BOOT_PAT = 80'h00FF00FFFF00FF00FF00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic [6:0]    req_addr = 7'd0;
    logic [2:0]    req_bit = 3'd0;
    logic          req_ready, rsp_valid, boot_done;
    logic [7:0]    rsp_data;
    logic [8*BW-1:0] boot_data;
    logic          CSB, STROBE, LOAD, VDDQ, PGENB;
    logic [9:0]    A;
    logic [7:0]    Q;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    efuse_access_ctrl #(
        .T_SETUP(T_SETUP), .T_PGM(T_PGM), .T_RD(T_RD), .T_HOLD(T_HOLD), .BOOT_WORDS(BW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_bit(req_bit),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .boot_done(boot_done), .boot_data(boot_data),
        .CSB(CSB), .STROBE(STROBE), .LOAD(LOAD), .VDDQ(VDDQ), .PGENB(PGENB),
        .A(A), .Q(Q)
    );

    task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] preset(input int i);
        logic [79:0] p;
        p = BOOT_PAT;
        if (i < BW) return p[8*i +: 8];
        return 8'(i * 37 + 11);
    endfunction

    // eFuse macro: read data latched while STROBE is high in read mode; a bit
    // is blown only by a program pulse of exactly T_PGM cycles.
    logic [7:0] fuse_mem [128];
    logic [7:0] q_reg = 8'h00;
    bit         fm_init = 1'b0;
    int         pgm_run = 0;
    logic [9:0] pgm_a = 10'd0;
    assign Q = q_reg;

    always @(posedge clk) begin
        if (!fm_init) begin
            for (int i = 0; i < 128; i++) fuse_mem[i] = preset(i);
            fm_init = 1'b1;
        end
        if (STROBE === 1'b1 && CSB === 1'b0 && PGENB === 1'b1 && LOAD === 1'b1)
            q_reg <= fuse_mem[A[6:0]];
        if (STROBE === 1'b1 && CSB === 1'b0 && PGENB === 1'b0 && VDDQ === 1'b1) begin
            pgm_run++;
            pgm_a = A;
        end else if (STROBE !== 1'b1) begin
            if (pgm_run == T_PGM) fuse_mem[pgm_a[6:0]][pgm_a[9:7]] = 1'b1;
            pgm_run = 0;
        end
    end

    // Strobe-length / response monitors, cycle counter
    int cyc = 0;
    int st_run = 0;
    int last_len = 0;
    bit st_pgm_ok = 1'b0;
    bit last_pgm_ok = 1'b0;
    int rsp_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (STROBE === 1'b1) begin
            if (st_run == 0) st_pgm_ok = 1'b1;
            st_pgm_ok = st_pgm_ok && (VDDQ === 1'b1) && (PGENB === 1'b0);
            st_run++;
        end else if (st_run != 0) begin
            last_len    = st_run;
            last_pgm_ok = st_pgm_ok;
            st_run      = 0;
        end
    end

    // Reference model: each operation is a timeline of offsets k from its
    // launch cycle: k=1..S setup, S+1..S+P strobe, ..S+P+H hold, then response.
    logic [7:0]      exp_mem [128];
    bit              mem_init = 1'b0;
    bit              chk_en = 1'b0;
    bit              m_active = 1'b0, m_boot = 1'b0, m_done = 1'b0, m_wr = 1'b0;
    int              m_k = 0, m_idx = 0;
    logic [6:0]      m_addr = 7'd0;
    logic [2:0]      m_bit = 3'd0;
    logic [8*BW-1:0] exp_boot = '0;
    logic [13:0]     prev_pins = 14'd0;
    bit              prev_strobe = 1'b0;

    always @(negedge clk) begin : model
        int          plen, dcyc;
        logic [14:0] e_pins;
        logic        e_ready, e_rv, e_bd;
        logic [7:0]  e_rd;
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) exp_mem[i] = preset(i);
            mem_init = 1'b1;
        end
        plen    = m_wr ? T_PGM : T_RD;
        dcyc    = T_SETUP + plen + T_HOLD + 1;
        e_pins  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0};
        e_ready = 1'b0;
        e_rv    = 1'b0;
        e_bd    = m_done;
        e_rd    = 8'h00;
        if (!m_active) begin
            e_ready = 1'b1;
        end else if (m_k >= 1 && m_k < dcyc) begin
            e_pins = m_wr ? {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_bit, m_addr}
                          : {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, m_addr};
            e_pins[13] = (m_k > T_SETUP) && (m_k <= T_SETUP + plen);
        end else if (m_k == dcyc) begin
            if (m_boot) begin
                exp_boot[8*m_idx +: 8] = exp_mem[m_idx];
                if (m_idx == BW - 1) e_bd = 1'b1;
            end else begin
                e_rv = 1'b1;
                e_rd = m_wr ? 8'h00 : exp_mem[m_addr];
                if (m_wr) exp_mem[m_addr][m_bit] = 1'b1;
            end
        end
        if (chk_en) begin
            chk_v("pins", 128'({CSB, STROBE, LOAD, PGENB, VDDQ, A}), 128'(e_pins));
            chk_v("req_ready", 128'(req_ready), 128'(e_ready));
            chk_v("rsp_valid", 128'(rsp_valid), 128'(e_rv));
            chk_v("boot_done", 128'(boot_done), 128'(e_bd));
            if (e_rv || (m_active && m_k == 0))
                chk_v("rsp_data", 128'(rsp_data), 128'(e_rd));
            if (!m_active || m_k == 0 || m_k == dcyc)
                chk_v("boot_data", 128'(boot_data), 128'(exp_boot));
            if (STROBE === 1'b1 && prev_strobe)
                chk_v("strobe_stable", 128'({CSB, LOAD, PGENB, VDDQ, A}), 128'(prev_pins));
        end
        prev_strobe = (STROBE === 1'b1);
        prev_pins   = {CSB, LOAD, PGENB, VDDQ, A};
        if (rst) begin
            chk_en   = 1'b1;
            m_active = 1'b1;
            m_k      = 0;
            m_boot   = 1'b1;
            m_idx    = 0;
            m_wr     = 1'b0;
            m_addr   = 7'd0;
            m_bit    = 3'd0;
            m_done   = 1'b0;
            exp_boot = '0;
        end else if (!m_active) begin
            if (req_valid) begin
                m_active = 1'b1;
                m_k      = 1;
                m_boot   = 1'b0;
                m_wr     = req_wr;
                m_addr   = req_addr;
                m_bit    = req_bit;
            end
        end else if (m_k == dcyc) begin
            if (m_boot && m_idx < BW - 1) begin
                m_idx++;
                m_k    = 0;
                m_addr = 7'(m_idx);
                m_wr   = 1'b0;
            end else begin
                m_active = 1'b0;
                if (m_boot) m_done = 1'b1;
            end
        end else begin
            m_k++;
        end
    end

    logic [1:0] boot_first = 2'b00;

    task automatic wait_boot(output int n);
        n = 0;
        @(negedge clk);
        boot_first = {STROBE, CSB};
        while (boot_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_req(input bit wr, input logic [6:0] ad, input logic [2:0] b,
                          input bit hold, output int acc_cyc);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        acc_cyc = 0;
        req_wr = wr;
        req_addr = ad;
        req_bit = b;
        req_valid = 1'b1;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = (req_ready === 1'b1);
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        chk_v("req_accepted", 128'(acc), 128'(1'b1));
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [7:0] d);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        d = 8'h00;
        while (!got && n < 400) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                d = rsp_data;
            end
            n++;
        end
        @(posedge clk);
        #1;
        chk_v("rsp_seen", 128'(got), 128'(1'b1));
    endtask

    initial begin : watchdog
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         c1, c2, nb, cnt, n, rc0;
        logic [7:0] d;
        bit         wr;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        wait_boot(nb);
        chk_i("boot_latency", nb, 99);
        chk_v("boot_data_lit", 128'(boot_data), 128'(80'h00FF00FFFF00FF00FF00));
        @(posedge clk);
        #1;

        do_req(1'b0, 7'd1, 3'd0, 1'b0, c1);
        wait_rsp(d);
        chk_v("rd1_data", 128'(d), 128'(8'hFF));
        chk_i("rd1_strobe_len", last_len, 4);

        do_req(1'b1, 7'd0, 3'd3, 1'b0, c1);
        wait_rsp(d);
        chk_v("pgm_rsp_data", 128'(d), 128'(8'h00));
        chk_i("pgm_strobe_len", last_len, 20);
        chk_v("pgm_mode_during_strobe", 128'(last_pgm_ok), 128'(1'b1));
        do_req(1'b0, 7'd0, 3'd0, 1'b0, c1);
        wait_rsp(d);
        chk_v("rd0_after_pgm", 128'(d), 128'(8'h08));

        do_req(1'b0, 7'd5, 3'd0, 1'b1, c1);
        do_req(1'b0, 7'd6, 3'd0, 1'b1, c2);
        req_valid = 1'b0;
        chk_i("b2b_gap", c2 - c1, 10);
        wait_rsp(d);
        chk_v("b2b_second_data", 128'(d), 128'(8'hFF));

        rc0 = rsp_cnt;
        do_req(1'b1, 7'd2, 3'd0, 1'b0, c1);
        cnt = 0;
        n = 0;
        while (cnt < 9 && n < 200) begin
            @(negedge clk);
            if (STROBE === 1'b1) cnt++;
            n++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_boot(nb);
        chk_v("rst_strobe_csb", 128'(boot_first), 128'(2'b01));
        chk_i("rst_boot_latency", nb, 99);
        chk_i("rst_no_rsp", rsp_cnt, rc0);
        chk_v("boot_data_after_rst", 128'(boot_data), 128'(80'h00FF00FFFF00FF00FF08));
        @(posedge clk);
        #1;
        do_req(1'b0, 7'd2, 3'd0, 1'b0, c1);
        wait_rsp(d);
        chk_v("rd2_aborted_pgm", 128'(d), 128'(8'h00));

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            do_req(wr, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0, c1);
            wait_rsp(d);
            chk_i("rand_strobe_len", last_len, wr ? T_PGM : T_RD);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/efuse_access_ctrl.md
EFUSE_ACCESS_CTRL -- requirements
Module: efuse_access_ctrl

Interface
REQ-001 SHALL have parameter T_SETUP, default 2: cycles from address/mode setup to STROBE rise (legal range 1..255).
REQ-002 SHALL have parameter T_PGM, default 20: STROBE-high cycles for a program pulse (1..255).
REQ-003 SHALL have parameter T_RD, default 4: STROBE-high cycles for a read pulse (1..255).
REQ-004 SHALL have parameter T_HOLD, default 2: cycles after STROBE fall before the mode pins return to idle (1..255).
REQ-005 SHALL have parameter BOOT_WORDS, default 10: words auto-read after reset from addresses 0..BOOT_WORDS-1 (1..128).
REQ-006 Port list: clk  in  1  single clock; all logic rises on posedge clk.
REQ-007 Port list: rst  in  1  synchronous, active-high reset.
REQ-008 Port list: req_valid in 1, req_ready out 1, req_wr in 1 (1=program, 0=read), req_addr in 7 (word address), req_bit in 3 (bit to blow; ignored on read).
REQ-009 Port list: rsp_valid out 1 (one-cycle pulse), rsp_data out 8 (read data; 0 after a program).
REQ-010 Port list: boot_done out 1, boot_data out 8*BOOT_WORDS (word n at bits [8n+7:8n]).
REQ-011 Port list: CSB, STROBE, LOAD, VDDQ, PGENB out 1 each; A out 10 ({bit,addr}); Q in 8, all to the eFuse macro.

Function
REQ-012 Idle pin state SHALL be CSB=1, STROBE=0, LOAD=0, PGENB=1, VDDQ=0, A=0.
REQ-013 FSM states SHALL be BOOT_REQ, IDLE, SETUP, PULSE, HOLD, DONE.
REQ-014 Handshake: request accepted on the cycle req_valid & req_ready; req_ready=1 only in IDLE.
REQ-015 On accept, request SHALL be latched and FSM enters SETUP; pins move to mode values that same next cycle.
REQ-016 Program mode pins: CSB=0, PGENB=0, LOAD=0, VDDQ=1, A={req_bit,req_addr}.
REQ-017 Read mode pins: CSB=0, PGENB=1, LOAD=1, VDDQ=0, A={3'b000,req_addr}.
REQ-018 SETUP SHALL last T_SETUP cycles with STROBE=0; PULSE SHALL hold STROBE=1 for exactly T_PGM (program) or T_RD (read) cycles.
REQ-019 HOLD SHALL last T_HOLD cycles with STROBE=0 and mode pins unchanged; on the first HOLD cycle, for reads, Q SHALL be captured.
REQ-020 DONE SHALL last one cycle: pins return to idle values, rsp_valid=1, rsp_data=captured Q (read) or 0 (program); next state IDLE.
REQ-021 A/mode pins SHALL never change while STROBE=1.
REQ-022 One shared 8-bit down-counter SHALL time SETUP/PULSE/HOLD; loaded with N-1 on state entry, transition at zero.
REQ-023 Boot: after reset the FSM SHALL read addresses 0..BOOT_WORDS-1 in ascending order via the read sequence, storing each into boot_data; no rsp_valid pulses for boot reads.
REQ-024 boot_done SHALL assert in the DONE cycle of the last boot read and remain 1 until reset; req_ready stays 0 until then.
REQ-025 boot_data SHALL be read-only after boot; programs do not update it.
REQ-026 req_valid with illegal content is impossible (all encodings legal); req_addr >= BOOT_WORDS SHALL still be issued to the macro.

Reset
REQ-027 While rst=1, all pins SHALL hold idle values, req_ready=0, rsp_valid=0, rsp_data=0, boot_done=0, boot_data=0, counter=0, boot index=0, state=BOOT_REQ.
REQ-028 rst asserted mid-pulse SHALL drop STROBE to 0 and CSB to 1 on the next clock edge; aborted operation gives no response; boot restarts from word 0.

Structure
REQ-029 FSM state enum and idle pin constants SHALL live in shared package efuse_pkg.
REQ-030 Timing counter SHALL be sub-module efuse_timer (load, value, zero flag).

Verification
REQ-031 Reset release with macro preset words 00,FF,00,FF,00,FF,FF,00,FF,00 -> boot_done after 10 reads, boot_data = 0x00FF00FFFF00FF00FF00 (word9..word0).
REQ-032 Read addr 1 after boot -> STROBE high exactly 4 cycles, rsp_valid one cycle, rsp_data=0xFF.
REQ-033 Program addr 0 bit 3, then read addr 0 -> STROBE high 20 cycles with VDDQ=1, PGENB=0; read returns 0x08.
REQ-034 req_valid held high continuously with two requests -> second accepted only after DONE, req_ready low throughout SETUP..DONE.
REQ-035 rst pulsed on cycle 10 of a program pulse -> STROBE=0 next cycle, no rsp_valid, boot sequence reruns from address 0.
REQ-036 Checker: A and mode pins stable on every cycle STROBE=1, across all scenarios.
